// File: rtl/tpu_skew_feeder_if.sv
// Load-side handshake bundle for the systolic skew feeder: one data and one
// weight vector per beat, valid/ready flow control.
interface tpu_skew_feeder_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BIT_WIDTH = 8
) ();

  logic                         in_valid;
  logic                         in_ready;
  logic [BIT_WIDTH*DEPTH-1:0]   in_data;
  logic [BIT_WIDTH*DEPTH-1:0]   in_wt;

  modport master (
    output in_valid,
    output in_data,
    output in_wt,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_wt,
    output in_ready
  );

endinterface

// File: rtl/tpu_skew_feeder.sv
// Buffers a DEPTH x DEPTH tile of data/weight vectors, then streams them diagonally
// skewed into a systolic array, flushes the pipeline and pulses done.
module tpu_skew_feeder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  tpu_skew_feeder_if.slave           ld,
  output logic [BIT_WIDTH*DEPTH-1:0] data_arr,
  output logic [BIT_WIDTH*DEPTH-1:0] wt_arr,
  output logic                       control,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned VecW = BIT_WIDTH * DEPTH;
  localparam int unsigned CntW = $clog2(2 * DEPTH);

  localparam logic [CntW-1:0] LastBeat  = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] LastStep  = CntW'(2 * DEPTH - 2);
  localparam logic [CntW-1:0] FlushLast = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StLoad,
    StStream,
    StFlush,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] beat_q, beat_d;
  logic [CntW-1:0] step_q, step_d;

  logic [VecW-1:0] data_buf_q [DEPTH];
  logic [VecW-1:0] data_buf_d [DEPTH];
  logic [VecW-1:0] wt_buf_q   [DEPTH];
  logic [VecW-1:0] wt_buf_d   [DEPTH];

  logic [VecW-1:0] data_arr_q, data_arr_d;
  logic [VecW-1:0] wt_arr_q, wt_arr_d;
  logic            control_q, control_d;

  logic            load_en;
  logic            emit;
  logic [CntW-1:0] t_next;

  // Next-state logic. emit/t_next select which skew step the output registers
  // capture on this edge, so step t is visible while step_q == t.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    step_d    = step_q;
    load_en   = 1'b0;
    emit      = 1'b0;
    t_next    = '0;
    control_d = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (ld.in_valid) begin
          load_en = 1'b1;
          if (beat_q == LastBeat) begin
            state_d   = StStream;
            beat_d    = '0;
            step_d    = '0;
            emit      = 1'b1;
            t_next    = '0;
            control_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StStream: begin
        if (step_q == LastStep) begin
          state_d = StFlush;
          step_d  = '0;
        end else begin
          step_d    = step_q + 1'b1;
          emit      = 1'b1;
          t_next    = step_q + 1'b1;
          control_d = 1'b1;
        end
      end
      StFlush: begin
        if (step_q == FlushLast) begin
          state_d = StDone;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StLoad;
        beat_d  = '0;
        step_d  = '0;
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // Buffer view including the beat being written, so the final beat is
  // usable for step 0 on the same edge.
  always_comb begin
    data_buf_d = data_buf_q;
    wt_buf_d   = wt_buf_q;
    if (load_en) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (beat_q == CntW'(k)) begin
          data_buf_d[k] = ld.in_data;
          wt_buf_d[k]   = ld.in_wt;
        end
      end
    end
  end

  // Lane i at step t carries entry t-i of the buffer.
  always_comb begin
    data_arr_d = '0;
    wt_arr_d   = '0;
    if (emit) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        for (int k = 0; k < int'(DEPTH); k++) begin
          if (k + i == int'(t_next)) begin
            data_arr_d[i*BIT_WIDTH +: BIT_WIDTH] = data_buf_d[k][i*BIT_WIDTH +: BIT_WIDTH];
            wt_arr_d[i*BIT_WIDTH +: BIT_WIDTH]   = wt_buf_d[k][i*BIT_WIDTH +: BIT_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StLoad;
      beat_q     <= '0;
      step_q     <= '0;
      data_arr_q <= '0;
      wt_arr_q   <= '0;
      control_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      step_q     <= step_d;
      data_arr_q <= data_arr_d;
      wt_arr_q   <= wt_arr_d;
      control_q  <= control_d;
    end
  end

  always_ff @(posedge clk) begin
    data_buf_q <= data_buf_d;
    wt_buf_q   <= wt_buf_d;
  end

  assign ld.in_ready = (state_q == StLoad);
  assign busy        = (state_q != StLoad);
  assign done        = (state_q == StDone);
  assign data_arr    = data_arr_q;
  assign wt_arr      = wt_arr_q;
  assign control     = control_q;

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Randomized bench for tpu_skew_feeder: a timeline model predicts every output each
// cycle, and literal checks pin the skew pattern and cycle counts for a known tile.
module tb_tpu_skew_feeder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned VecW  = DEPTH * BW;

  logic            clk;
  logic            reset;
  logic [VecW-1:0] data_arr;
  logic [VecW-1:0] wt_arr;
  logic            control;
  logic            busy;
  logic            done;

  tpu_skew_feeder_if #(.DEPTH(DEPTH), .BIT_WIDTH(BW)) ld ();

  tpu_skew_feeder #(.DEPTH(DEPTH), .BIT_WIDTH(BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld       (ld.slave),
    .data_arr (data_arr),
    .wt_arr   (wt_arr),
    .control  (control),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an expected-output timeline; empty means waiting for load beats.
  typedef struct {
    logic [VecW-1:0] d;
    logic [VecW-1:0] w;
    bit              ctl;
    bit              dn;
  } exp_t;

  exp_t            sched[$];
  logic [VecW-1:0] mdata [DEPTH];
  logic [VecW-1:0] mwt   [DEPTH];
  int              nbeat = 0;
  bit              model_ok = 0;

  task automatic build_schedule();
    exp_t e;
    int   k;
    for (int t = 0; t < 2 * DEPTH - 1; t++) begin
      e.d = '0; e.w = '0; e.ctl = 1'b1; e.dn = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        k = t - i;
        if (k >= 0 && k < DEPTH) begin
          e.d[i*BW +: BW] = mdata[k][i*BW +: BW];
          e.w[i*BW +: BW] = mwt[k][i*BW +: BW];
        end
      end
      sched.push_back(e);
    end
    for (int f = 0; f < DEPTH + 1; f++) begin
      e.d = '0; e.w = '0; e.ctl = 1'b0; e.dn = 1'b0;
      sched.push_back(e);
    end
    e.d = '0; e.w = '0; e.ctl = 1'b0; e.dn = 1'b1;
    sched.push_back(e);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      sched.delete();
      nbeat    = 0;
      model_ok = 1'b1;
    end else if (sched.size() != 0) begin
      void'(sched.pop_front());
    end else if (ld.in_valid) begin
      mdata[nbeat] = ld.in_data;
      mwt[nbeat]   = ld.in_wt;
      nbeat++;
      if (nbeat == DEPTH) begin
        nbeat = 0;
        build_schedule();
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit   rdy;
    if (model_ok) begin
      if (sched.size() != 0) begin
        e   = sched[0];
        rdy = 1'b0;
      end else begin
        e.d = '0; e.w = '0; e.ctl = 1'b0; e.dn = 1'b0;
        rdy = 1'b1;
      end
      check("cyc_data_arr", 64'(data_arr), 64'(e.d));
      check("cyc_wt_arr", 64'(wt_arr), 64'(e.w));
      check("cyc_control", 64'(control), 64'(e.ctl));
      check("cyc_done", 64'(done), 64'(e.dn));
      check("cyc_in_ready", 64'(ld.in_ready), 64'(rdy));
      check("cyc_busy", 64'(busy), 64'(!rdy));
    end
  end

  // Stimulus
  logic [VecW-1:0] tile_d [DEPTH];
  logic [VecW-1:0] tile_w [DEPTH];

  task automatic drive_idle(input bit junk);
    ld.in_valid = junk;
    ld.in_data  = VecW'($urandom());
    ld.in_wt    = VecW'($urandom());
  endtask

  task automatic pattern_tile();
    for (int k = 0; k < DEPTH; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tile_d[k][i*BW +: BW] = 8'((k << 4) | i);
        tile_w[k][i*BW +: BW] = 8'((k << 4) | i) ^ 8'h80;
      end
    end
  endtask

  task automatic random_tile();
    for (int k = 0; k < DEPTH; k++) begin
      tile_d[k] = VecW'($urandom());
      tile_w[k] = VecW'($urandom());
    end
  endtask

  // Leaves the bench at the negedge where step 0 should be visible.
  task automatic load_tile(input bit toggle, input bit junk);
    int k;
    bit ph;
    k  = 0;
    ph = 1'b0;
    while (k < DEPTH) begin
      @(negedge clk);
      if (toggle && ph) begin
        drive_idle(1'b0);
      end else begin
        ld.in_valid = 1'b1;
        ld.in_data  = tile_d[k];
        ld.in_wt    = tile_w[k];
        k++;
      end
      ph = !ph;
    end
    @(negedge clk);
    drive_idle(junk);
  endtask

  task automatic observe_tile(input bit pin, input bit junk);
    int t;
    int flush_cnt;
    bit got_done;
    t         = 0;
    flush_cnt = 0;
    got_done  = 1'b0;
    if (pin) check("ready_low_after_last_beat", 64'(ld.in_ready), 64'd0);
    for (int cyc = 0; cyc < 4 * DEPTH + 8 && !got_done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        drive_idle(junk);
      end
      if (control) begin
        if (pin && t == 0) begin
          check("t0_data", 64'(data_arr), 64'h00000000);
          check("t0_wt", 64'(wt_arr), 64'h00000080);
        end
        if (pin && t == 3) begin
          check("t3_data", 64'(data_arr), 64'h03122130);
          check("t3_wt", 64'(wt_arr), 64'h8392a1b0);
        end
        if (pin && t == 6) begin
          check("t6_data", 64'(data_arr), 64'h33000000);
          check("t6_wt", 64'(wt_arr), 64'hb3000000);
        end
        t++;
      end else if (done) begin
        got_done = 1'b1;
      end else if (t > 0) begin
        flush_cnt++;
      end
    end
    check("stream_cycles", 64'(t), 64'(2 * DEPTH - 1));
    check("flush_cycles", 64'(flush_cnt), 64'(DEPTH + 1));
    check("done_seen", 64'(got_done), 64'd1);
    @(negedge clk);
    drive_idle(1'b0);
    check("ready_after_done", 64'(ld.in_ready), 64'd1);
  endtask

  task automatic pulse_reset(input bit valid_during);
    reset = 1'b1;
    drive_idle(valid_during);
    @(negedge clk);
    check("rst_data_zero", 64'(data_arr), 64'd0);
    check("rst_wt_zero", 64'(wt_arr), 64'd0);
    check("rst_control_low", 64'(control), 64'd0);
    check("rst_done_low", 64'(done), 64'd0);
    check("rst_ready_high", 64'(ld.in_ready), 64'd1);
    reset = 1'b0;
    drive_idle(1'b0);
  endtask

  task automatic expect_no_done(input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done || control) seen++;
    end
    check("no_activity_after_abandon", 64'(seen), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive_idle(1'b1);
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(ld.in_ready), 64'd1);
    reset = 1'b0;
    drive_idle(1'b0);

    // Known tile back-to-back, then junk beats throughout stream/flush.
    pattern_tile();
    load_tile(1'b0, 1'b1);
    observe_tile(1'b1, 1'b1);

    // Same tile with in_valid toggling.
    load_tile(1'b1, 1'b0);
    observe_tile(1'b1, 1'b0);

    // Reset at stream step 2, then a fresh tile.
    random_tile();
    load_tile(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("at_t2_control", 64'(control), 64'd1);
    pulse_reset(1'b1);
    expect_no_done(15);
    random_tile();
    load_tile(1'b0, 1'b0);
    observe_tile(1'b0, 1'b0);

    // Two consecutive random tiles.
    random_tile();
    load_tile(1'b0, 1'b0);
    observe_tile(1'b0, 1'b1);
    random_tile();
    load_tile(1'b0, 1'b0);
    observe_tile(1'b0, 1'b0);

    // Reset mid-load, then mid-flush.
    random_tile();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ld.in_valid = 1'b1;
      ld.in_data  = tile_d[k];
      ld.in_wt    = tile_w[k];
    end
    @(negedge clk);
    pulse_reset(1'b1);
    expect_no_done(6);
    random_tile();
    load_tile(1'b0, 1'b0);
    repeat (2 * DEPTH + 1) @(negedge clk);
    pulse_reset(1'b0);
    expect_no_done(10);

    // Random tiles with random valid gaps and junk.
    for (int n = 0; n < 6; n++) begin
      random_tile();
      load_tile(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      observe_tile(1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tpu_skew_feeder.md
TPU_SKEW_FEEDER -- requirements
Module: tpu_skew_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the systolic array edge length (rows = columns).
REQ-002 The block SHALL have parameter BIT_WIDTH, default 8, giving the width of one data or weight element.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid, input, 1 bit: the load beat on in_data and in_wt is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts a load beat this cycle.
REQ-007 Port in_data, input, BIT_WIDTH*DEPTH bits: one data vector; lane i is bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-008 Port in_wt, input, BIT_WIDTH*DEPTH bits: one weight vector, with the same lane layout as in_data.
REQ-009 Port data_arr, output, BIT_WIDTH*DEPTH bits: skewed data presented to the array row inputs.
REQ-010 Port wt_arr, output, BIT_WIDTH*DEPTH bits: skewed weights presented to the array column inputs.
REQ-011 Port control, output, 1 bit: array compute enable; high only while streaming.
REQ-012 Port busy, output, 1 bit: high in every state except LOAD.
REQ-013 Port done, output, 1 bit: one-cycle pulse when a tile has fully streamed and flushed.

Function
REQ-014 The block SHALL implement four states: LOAD, STREAM, FLUSH, DONE.
REQ-015 LOAD behaviour:
- in_ready SHALL be 1.
- A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising edge.
- Beat k (k = 0..DEPTH-1) SHALL be written to data_buf[k] and wt_buf[k].
REQ-016 When beat DEPTH-1 is accepted, the block SHALL move to STREAM with stream counter t = 0.
REQ-017 in_ready SHALL be 0 in STREAM, FLUSH and DONE; in_valid in those states SHALL be ignored with no buffer write.
REQ-018 In STREAM, for stream step t = 0..2*DEPTH-2:
- data_arr lane i SHALL equal lane i of data_buf[t-i] when 0 <= t-i <= DEPTH-1, and 0 otherwise.
- wt_arr lane j SHALL equal lane j of wt_buf[t-j] when 0 <= t-j <= DEPTH-1, and 0 otherwise.
REQ-019 data_arr, wt_arr and control SHALL be registered outputs with these timing rules:
- Step t=0 SHALL be visible the cycle after the edge that accepts the final load beat.
- Each subsequent cycle SHALL advance t by 1.
REQ-020 control SHALL be 1 exactly for the 2*DEPTH-1 cycles that carry STREAM steps, and 0 at all other times.
REQ-021 After step 2*DEPTH-2, the block SHALL enter FLUSH:
- FLUSH lasts DEPTH+1 cycles.
- data_arr and wt_arr SHALL be 0 and control SHALL be 0 throughout, to drain the array pipeline and its output register.
REQ-022 After the last FLUSH cycle, the block SHALL enter DONE for exactly one cycle:
- done SHALL be 1 in that cycle.
- The block SHALL then return to LOAD with the beat counter at 0.
REQ-023 The beat counter and stream counter SHALL each be wide enough for 2*DEPTH-1 steps and SHALL never wrap within a tile.
REQ-024 Buffers SHALL NOT be cleared between tiles; each new tile fully overwrites all DEPTH entries before streaming.
REQ-025 busy SHALL be 1 in STREAM, FLUSH and DONE, and 0 in LOAD.

Reset
REQ-026 While reset is 1 at a rising edge, the block SHALL apply the following reset values:
- State SHALL be LOAD and both counters SHALL be 0.
- data_arr and wt_arr SHALL be 0.
- control, busy and done SHALL be 0.
- in_ready SHALL be 1 from the cycle after reset deasserts.
REQ-027 Reset SHALL take priority over every other event, including in_valid in the same cycle.
REQ-028 Reset asserted mid-LOAD, mid-STREAM or mid-FLUSH SHALL abandon the tile: no done pulse and no further nonzero outputs.
REQ-029 Buffer contents need not be reset.

Verification (DEPTH=4, BIT_WIDTH=8; beat k lane i = 8'h{k}{i}, e.g. beat 2 lane 1 = 8'h21; weights = data XOR 8'h80)
REQ-030 Reset, then 4 back-to-back beats with in_valid held 1:
- in_ready falls after the 4th beat.
- t=0: data_arr = {00,00,00,8'h00}, with lane0=8'h00.
- t=3: lanes 0..3 = 30,21,12,03.
- t=6: lane3 = 8'h33 and lanes 0..2 = 0.
- wt_arr lanes match the same pattern XOR 80 where nonzero.
REQ-031 Same tile loaded with in_valid toggling 1,0,1,0...: exactly 4 beats are stored and the stream output is identical to REQ-030.
REQ-032 Cycle counting: control is high for exactly 7 cycles, followed by 5 zero FLUSH cycles, then done high for 1 cycle, then in_ready=1 on the next cycle.
REQ-033 in_valid=1 with different data throughout STREAM/FLUSH: stream outputs are unchanged from REQ-030 and no beat is accepted.
REQ-034 Reset pulsed at stream step t=2: the next cycle has all outputs 0, in_ready=1, no done pulse; a fresh tile then streams correctly.
REQ-035 Two tiles loaded consecutively with different values: the second stream contains only second-tile values, with zero leakage from the first.
